// File: rtl/switch_pkg.sv
// Shared types and sizing for the four-port packet switch.
package switch_pkg;
    localparam int unsigned NPORTS     = 4;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;

    typedef logic [3:0] port_mask_t;

    typedef struct packed {
        logic [1:0]        source;
        port_mask_t        target;
        logic [DATA_W-1:0] data;
    } packet_t;
endpackage

// File: rtl/port_if.sv
// One switch port: ingress packet strobe plus egress packet strobe.
interface port_if;
    import switch_pkg::*;

    logic              valid_in;
    logic [1:0]        source_in;
    port_mask_t        target_in;
    logic [DATA_W-1:0] data_in;
    logic              valid_out;
    logic [1:0]        source_out;
    port_mask_t        target_out;
    logic [DATA_W-1:0] data_out;

    modport master (
        output valid_in, source_in, target_in, data_in,
        input  valid_out, source_out, target_out, data_out
    );

    modport slave (
        input  valid_in, source_in, target_in, data_in,
        output valid_out, source_out, target_out, data_out
    );
endinterface

// File: rtl/switch_fifo.sv
// Registered synchronous ingress FIFO; full/empty are judged on the count at cycle start.
module switch_fifo
    import switch_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  packet_t wdata,
    output packet_t head,
    output logic    fifo_empty
);
    packet_t          mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             do_push, do_pop;

    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign do_push    = push && !fifo_full;
    assign do_pop     = pop && !fifo_empty;
    assign head       = mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_count <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/switch_port.sv
// Per-port slice: ingress FIFO, remaining-target mask of the FIFO head, egress output register.
module switch_port
    import switch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    port_if.slave      port,
    input  port_mask_t grant,
    output port_mask_t req_mask,
    output packet_t    head,
    input  logic       out_valid,
    input  packet_t    out_pkt
);
    packet_t    wdata;
    logic       push, pop, fifo_empty;
    port_mask_t mask_q, mask_d;
    logic       valid_q;
    packet_t    out_q;

    assign wdata    = {port.source_in, port.target_in, port.data_in};
    assign push     = port.valid_in && (port.target_in != '0);
    assign req_mask = mask_q;

    switch_fifo port_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .wdata      (wdata),
        .head       (head),
        .fifo_empty (fifo_empty)
    );

    // A zero mask means no head is armed; the next head loads one cycle after a pop.
    always_comb begin
        mask_d = mask_q;
        pop    = 1'b0;
        if (mask_q != '0) begin
            mask_d = mask_q & ~grant;
            pop    = (mask_d == '0);
        end else if (!fifo_empty) begin
            mask_d = head.target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q  <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            mask_q  <= mask_d;
            valid_q <= out_valid;
            if (out_valid) out_q <= out_pkt;
        end
    end

    assign port.valid_out  = valid_q;
    assign port.source_out = out_q.source;
    assign port.target_out = out_q.target;
    assign port.data_out   = out_q.data;
endmodule

// File: rtl/four_port_switch.sv
// Four-port single-beat packet switch with a round-robin arbiter per egress port.
module four_port_switch
    import switch_pkg::*;
(
    input logic   clk,
    input logic   rst_n,
    port_if.slave port0,
    port_if.slave port1,
    port_if.slave port2,
    port_if.slave port3
);
    port_mask_t req      [NPORTS];
    port_mask_t grant    [NPORTS];
    packet_t    head     [NPORTS];
    logic       eg_valid [NPORTS];
    packet_t    eg_pkt   [NPORTS];
    logic [1:0] last_q   [NPORTS];
    logic [1:0] last_d   [NPORTS];

    // grant[i][k]: egress k takes the head of ingress i this cycle.
    always_comb begin
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NPORTS; i++) grant[i] = '0;
        for (int k = 0; k < NPORTS; k++) begin
            eg_valid[k] = 1'b0;
            eg_pkt[k]   = '0;
            last_d[k]   = last_q[k];
            for (int off = 1; off <= NPORTS; off++) begin
                idx = last_q[k] + 2'(off);
                if (!eg_valid[k] && req[idx][k]) begin
                    eg_valid[k]    = 1'b1;
                    eg_pkt[k]      = head[idx];
                    grant[idx][k]  = 1'b1;
                    last_d[k]      = idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NPORTS; k++) last_q[k] <= '0;
        end else begin
            for (int k = 0; k < NPORTS; k++) last_q[k] <= last_d[k];
        end
    end

    switch_port port0_i (
        .clk (clk), .rst_n (rst_n), .port (port0), .grant (grant[0]), .req_mask (req[0]),
        .head (head[0]), .out_valid (eg_valid[0]), .out_pkt (eg_pkt[0])
    );
    switch_port port1_i (
        .clk (clk), .rst_n (rst_n), .port (port1), .grant (grant[1]), .req_mask (req[1]),
        .head (head[1]), .out_valid (eg_valid[1]), .out_pkt (eg_pkt[1])
    );
    switch_port port2_i (
        .clk (clk), .rst_n (rst_n), .port (port2), .grant (grant[2]), .req_mask (req[2]),
        .head (head[2]), .out_valid (eg_valid[2]), .out_pkt (eg_pkt[2])
    );
    switch_port port3_i (
        .clk (clk), .rst_n (rst_n), .port (port3), .grant (grant[3]), .req_mask (req[3]),
        .head (head[3]), .out_valid (eg_valid[3]), .out_pkt (eg_pkt[3])
    );
endmodule

// File: tb/tb_four_port_switch.sv
// Scoreboard bench for four_port_switch: per (source, egress) ordered expectation queues.
`timescale 1ns/1ps
module tb_four_port_switch;
    import switch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    port_if p0 ();
    port_if p1 ();
    port_if p2 ();
    port_if p3 ();

    four_port_switch dut (
        .clk (clk), .rst_n (rst_n), .port0 (p0), .port1 (p1), .port2 (p2), .port3 (p3)
    );

    logic              vin [4];
    logic [1:0]        sin [4];
    port_mask_t        tin [4];
    logic [DATA_W-1:0] din [4];
    logic              vout [4];
    logic [1:0]        sout [4];
    port_mask_t        tout [4];
    logic [DATA_W-1:0] dout [4];
    logic              full [4];
    logic              empty [4];
    logic [CNT_W-1:0]  cnt [4];

    assign p0.valid_in = vin[0]; assign p0.source_in = sin[0];
    assign p0.target_in = tin[0]; assign p0.data_in = din[0];
    assign p1.valid_in = vin[1]; assign p1.source_in = sin[1];
    assign p1.target_in = tin[1]; assign p1.data_in = din[1];
    assign p2.valid_in = vin[2]; assign p2.source_in = sin[2];
    assign p2.target_in = tin[2]; assign p2.data_in = din[2];
    assign p3.valid_in = vin[3]; assign p3.source_in = sin[3];
    assign p3.target_in = tin[3]; assign p3.data_in = din[3];
    assign vout[0] = p0.valid_out; assign sout[0] = p0.source_out;
    assign tout[0] = p0.target_out; assign dout[0] = p0.data_out;
    assign vout[1] = p1.valid_out; assign sout[1] = p1.source_out;
    assign tout[1] = p1.target_out; assign dout[1] = p1.data_out;
    assign vout[2] = p2.valid_out; assign sout[2] = p2.source_out;
    assign tout[2] = p2.target_out; assign dout[2] = p2.data_out;
    assign vout[3] = p3.valid_out; assign sout[3] = p3.source_out;
    assign tout[3] = p3.target_out; assign dout[3] = p3.data_out;
    assign full[0] = dut.port0_i.port_fifo.fifo_full; assign cnt[0] = dut.port0_i.port_fifo.fifo_count;
    assign full[1] = dut.port1_i.port_fifo.fifo_full; assign cnt[1] = dut.port1_i.port_fifo.fifo_count;
    assign full[2] = dut.port2_i.port_fifo.fifo_full; assign cnt[2] = dut.port2_i.port_fifo.fifo_count;
    assign full[3] = dut.port3_i.port_fifo.fifo_full; assign cnt[3] = dut.port3_i.port_fifo.fifo_count;
    assign empty[0] = dut.port0_i.port_fifo.fifo_empty;
    assign empty[1] = dut.port1_i.port_fifo.fifo_empty;
    assign empty[2] = dut.port2_i.port_fifo.fifo_empty;
    assign empty[3] = dut.port3_i.port_fifo.fifo_empty;

    int      checks = 0;
    int      errors = 0;
    packet_t exp_q [16][$];
    int      deliv [4];
    int      src_deliv [4];
    int      dropped [4];
    int      log0 [$];

    // Monitor: every egress copy must match the oldest pending copy of its (source, egress) pair.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (vout[k] === 1'b1) begin
                    packet_t got;
                    packet_t exp;
                    int      qi;
                    got.source = sout[k];
                    got.target = tout[k];
                    got.data   = dout[k];
                    qi = int'(sout[k]) * 4 + k;
                    checks++;
                    if (exp_q[qi].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_copy port%0d got src=%0d tgt=%b data=%h required none",
                                 k, got.source, got.target, got.data);
                    end else begin
                        exp = exp_q[qi].pop_front();
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL copy_fields port%0d got %h required %h", k, got, exp);
                        end
                    end
                    deliv[k]++;
                    src_deliv[got.source]++;
                    if (k == 0) log0.push_back(int'(got.source));
                end
            end
        end
    end

    task automatic clear_inputs();
        for (int p = 0; p < 4; p++) begin
            vin[p] = 1'b0; sin[p] = 2'(p); tin[p] = '0; din[p] = '0;
        end
    endtask

    task automatic clear_stats();
        for (int p = 0; p < 4; p++) begin
            deliv[p] = 0; src_deliv[p] = 0; dropped[p] = 0;
        end
        log0.delete();
    endtask

    // Called after inputs are driven: full is stable until the sampling edge.
    task automatic commit();
        for (int p = 0; p < 4; p++) begin
            if (vin[p] && tin[p] != '0) begin
                if (full[p]) dropped[p]++;
                else begin
                    for (int k = 0; k < 4; k++)
                        if (tin[p][k]) exp_q[p*4+k].push_back({sin[p], tin[p], din[p]});
                end
            end
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < 16; i++) n += exp_q[i].size();
        return n;
    endfunction

    task automatic wait_drain(input string name);
        int n = 0;
        while (pending() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pending() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d copies outstanding required 0", name, pending());
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) exp_q[i].delete();
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
    endtask

    task automatic test_reset();
        #1;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if ({vout[p], sout[p], tout[p], dout[p]} !== '0) begin
                errors++;
                $display("FAIL reset_out port%0d got %b/%0d/%b/%h required all 0",
                         p, vout[p], sout[p], tout[p], dout[p]);
            end
            checks++;
            if (cnt[p] !== '0 || empty[p] !== 1'b1 || full[p] !== 1'b0) begin
                errors++;
                $display("FAIL reset_fifo port%0d got cnt=%0d empty=%b full=%b required 0/1/0",
                         p, cnt[p], empty[p], full[p]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unicast();
        clear_stats();
        @(negedge clk);
        vin[0] = 1'b1; tin[0] = 4'b0100; din[0] = 8'hA5;
        commit();
        @(negedge clk);
        clear_inputs();
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (vout[2] !== 1'b0) begin
                errors++;
                $display("FAIL unicast_early cycle%0d got valid=%b required 0", c, vout[2]);
            end
            if (c == 0) @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (vout[2] !== 1'b1 || dout[2] !== 8'hA5 || sout[2] !== 2'd0 || tout[2] !== 4'b0100) begin
            errors++;
            $display("FAIL unicast_n2 got v=%b d=%h s=%0d t=%b required 1/a5/0/0100",
                     vout[2], dout[2], sout[2], tout[2]);
        end
        checks++;
        if (vout[0] !== 1'b0 || vout[1] !== 1'b0 || vout[3] !== 1'b0) begin
            errors++;
            $display("FAIL unicast_others got %b%b%b required 000", vout[0], vout[1], vout[3]);
        end
        @(negedge clk);
        checks++;
        if (vout[2] !== 1'b0 || dout[2] !== 8'hA5) begin
            errors++;
            $display("FAIL unicast_hold got v=%b d=%h required 0/a5", vout[2], dout[2]);
        end
        wait_drain("unicast");
    endtask

    task automatic test_multicast();
        clear_stats();
        @(negedge clk);
        vin[1] = 1'b1; tin[1] = 4'b1011; din[1] = 8'h3C;
        commit();
        @(negedge clk);
        clear_inputs();
        checks++;
        if (cnt[1] !== CNT_W'(1)) begin
            errors++;
            $display("FAIL multicast_count1 got %0d required 1", cnt[1]);
        end
        wait_drain("multicast");
        repeat (2) @(negedge clk);
        checks++;
        if (deliv[0] != 1 || deliv[1] != 1 || deliv[2] != 0 || deliv[3] != 1) begin
            errors++;
            $display("FAIL multicast_copies got %0d%0d%0d%0d required 1101",
                     deliv[0], deliv[1], deliv[2], deliv[3]);
        end
        checks++;
        if (cnt[1] !== '0) begin
            errors++;
            $display("FAIL multicast_count0 got %0d required 0", cnt[1]);
        end
    endtask

    task automatic test_overflow();
        int max3 = 0;
        reset_dut();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (int'(cnt[3]) > max3) max3 = int'(cnt[3]);
            for (int p = 0; p < 4; p++) begin
                vin[p] = (p == 3) || (c < 4);
                tin[p] = 4'b0001;
                din[p] = {2'(p), 6'(c)};
            end
            commit();
        end
        @(negedge clk);
        clear_inputs();
        checks++;
        if (max3 != FIFO_DEPTH) begin
            errors++;
            $display("FAIL overflow_full got max count %0d required %0d", max3, FIFO_DEPTH);
        end
        checks++;
        if (dropped[3] != 2 || dropped[0] + dropped[1] + dropped[2] != 0) begin
            errors++;
            $display("FAIL overflow_drops got p3=%0d others=%0d required 2/0",
                     dropped[3], dropped[0] + dropped[1] + dropped[2]);
        end
        wait_drain("overflow");
        repeat (2) @(negedge clk);
        checks++;
        if (src_deliv[3] + dropped[3] != 12) begin
            errors++;
            $display("FAIL overflow_sum got %0d required 12", src_deliv[3] + dropped[3]);
        end
        checks++;
        if ({empty[0], empty[1], empty[2], empty[3]} !== 4'b1111) begin
            errors++;
            $display("FAIL overflow_empty got %b%b%b%b required 1111",
                     empty[0], empty[1], empty[2], empty[3]);
        end
    endtask

    task automatic test_contention();
        int bad = 0;
        reset_dut();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int p = 0; p < 4; p++) begin
                vin[p] = 1'b1; tin[p] = 4'b0001; din[p] = {2'(p), 6'(c + 16)};
            end
            commit();
        end
        @(negedge clk);
        clear_inputs();
        wait_drain("contention");
        repeat (2) @(negedge clk);
        checks++;
        if (log0.size() != 32) begin
            errors++;
            $display("FAIL contention_total got %0d required 32", log0.size());
        end
        for (int i = 1; i < log0.size(); i++)
            if (log0[i] != (log0[i-1] + 1) % 4) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL contention_rotation got %0d out-of-order grants required 0", bad);
        end
        checks++;
        if (log0.size() > 0 && log0[0] != 1) begin
            errors++;
            $display("FAIL contention_first got src %0d required 1", log0[0]);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int p = 0; p < 4; p++) begin
                vin[p] = 1'b1; tin[p] = 4'b0001; din[p] = {2'(p), 6'(c + 32)};
            end
            commit();
        end
        @(negedge clk);
        clear_inputs();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) exp_q[i].delete();
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (vout[p] !== 1'b0 || cnt[p] !== '0) begin
                errors++;
                $display("FAIL midreset port%0d got v=%b cnt=%0d required 0/0", p, vout[p], cnt[p]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        @(negedge clk);
        vin[3] = 1'b1; tin[3] = 4'b0010; din[3] = 8'h77;
        commit();
        @(negedge clk);
        clear_inputs();
        wait_drain("midreset");
        repeat (2) @(negedge clk);
        checks++;
        if (deliv[1] != 1 || deliv[0] + deliv[2] + deliv[3] != 0) begin
            errors++;
            $display("FAIL midreset_route got p1=%0d others=%0d required 1/0",
                     deliv[1], deliv[0] + deliv[2] + deliv[3]);
        end
    endtask

    task automatic test_zero_mask();
        clear_stats();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vin[2] = 1'b1; tin[2] = 4'b0000; din[2] = 8'hEE;
            commit();
        end
        @(negedge clk);
        clear_inputs();
        checks++;
        if (cnt[2] !== '0) begin
            errors++;
            $display("FAIL zero_mask_count got %0d required 0", cnt[2]);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (deliv[0] + deliv[1] + deliv[2] + deliv[3] != 0) begin
            errors++;
            $display("FAIL zero_mask_out got %0d copies required 0",
                     deliv[0] + deliv[1] + deliv[2] + deliv[3]);
        end
    endtask

    initial begin
        clear_inputs();
        clear_stats();
        test_reset();
        test_unicast();
        test_multicast();
        test_overflow();
        test_contention();
        test_reset_mid();
        test_zero_mask();
        checks++;
        if (pending() != 0) begin
            errors++;
            $display("FAIL final_pending got %0d required 0", pending());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
